cache_mem_arbiter: RTL and testbench



---
 rtl/cache_arb_pkg.sv | 18 +
 rtl/cache_arb_order_fifo.sv | 65 ++++++
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I-cache / D-cache memory port arbiter.
package cache_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/cache_arb_order_fifo.sv
// In-order owner queue: remembers which cache issued each accepted transaction.
module cache_arb_order_fifo
    import cache_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  owner_t push_owner,
    input  logic   pop,
    output owner_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_t           slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = slots[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one sram-like memory port between I-cache and D-cache, routing responses in order.
// Define CACHE_ARB_RR_EN for round-robin on simultaneous requests (default: data has priority).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned OUTSTANDING_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    arb_state_t state;
    owner_t     lock_owner;
    owner_t     sel;
    owner_t     pair_winner;
    owner_t     head;
    logic       sel_valid;
    logic       q_full;
    logic       q_empty;
    logic       addr_hs;
    logic       resp_hs;

`ifdef CACHE_ARB_RR_EN
    owner_t     last_grant;

    always_comb pair_winner = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
`else
    always_comb pair_winner = OWN_DATA;
`endif

    // Once a grant is presented without addr_ok, the port stays with that owner.
    always_comb begin
        sel       = OWN_DATA;
        sel_valid = 1'b0;
        if (state == LOCKED) begin
            sel       = lock_owner;
            sel_valid = 1'b1;
        end else if (inst_req && data_req) begin
            sel       = pair_winner;
            sel_valid = 1'b1;
        end else if (data_req) begin
            sel       = OWN_DATA;
            sel_valid = 1'b1;
        end else if (inst_req) begin
            sel       = OWN_INST;
            sel_valid = 1'b1;
        end
    end

    always_comb begin
        mem_req   = sel_valid && !q_full;
        mem_wr    = (sel == OWN_DATA) ? data_wr    : inst_wr;
        mem_size  = (sel == OWN_DATA) ? data_size  : inst_size;
        mem_addr  = (sel == OWN_DATA) ? data_addr  : inst_addr;
        mem_wdata = (sel == OWN_DATA) ? data_wdata : inst_wdata;

        addr_hs      = mem_req && mem_addr_ok;
        inst_addr_ok = addr_hs && (sel == OWN_INST);
        data_addr_ok = addr_hs && (sel == OWN_DATA);

        resp_hs      = mem_data_ok && !q_empty;
        inst_data_ok = resp_hs && (head == OWN_INST);
        data_data_ok = resp_hs && (head == OWN_DATA);

        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lock_owner <= OWN_DATA;
`ifdef CACHE_ARB_RR_EN
            last_grant <= OWN_INST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state      <= LOCKED;
                        lock_owner <= sel;
                    end
                end
                LOCKED: begin
                    if (addr_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef CACHE_ARB_RR_EN
            if (addr_hs) begin
                last_grant <= sel;
            end
`endif
        end
    end

    cache_arb_order_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_order_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (addr_hs),
        .push_owner (sel),
        .pop        (resp_hs),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected owners are queued at grant and checked at response.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef CACHE_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int     checks = 0;
    int     errors = 0;
    owner_t exp_q[$];
    owner_t model_last;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .OUTSTANDING_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic owner_t both_winner();
        if (RR_MODE) begin
            return (model_last == OWN_INST) ? OWN_DATA : OWN_INST;
        end
        return OWN_DATA;
    endfunction

    task automatic idle_check(input string tag);
        chk({tag, "_mreq"},  32'(mem_req),      32'd0);
        chk({tag, "_iaok"},  32'(inst_addr_ok), 32'd0);
        chk({tag, "_daok"},  32'(data_addr_ok), 32'd0);
        chk({tag, "_idok"},  32'(inst_data_ok), 32'd0);
        chk({tag, "_ddok"},  32'(data_data_ok), 32'd0);
    endtask

    task automatic chk_grant(input string tag, input owner_t w, input logic [31:0] addr);
        chk({tag, "_mreq"},  32'(mem_req),      32'd1);
        chk({tag, "_maddr"}, mem_addr,          addr);
        chk({tag, "_iaok"},  32'(inst_addr_ok), 32'(w == OWN_INST));
        chk({tag, "_daok"},  32'(data_addr_ok), 32'(w == OWN_DATA));
        exp_q.push_back(w);
        model_last = w;
    endtask

    task automatic resp_drive(input string tag, input logic [31:0] rd);
        owner_t h;
        mem_rdata   = rd;
        mem_data_ok = 1'b1;
        #1;
        chk({tag, "_irdata"}, inst_rdata, rd);
        chk({tag, "_drdata"}, data_rdata, rd);
        if (exp_q.size() == 0) begin
            chk({tag, "_idok"}, 32'(inst_data_ok), 32'd0);
            chk({tag, "_ddok"}, 32'(data_data_ok), 32'd0);
        end else begin
            h = exp_q.pop_front();
            chk({tag, "_idok"}, 32'(inst_data_ok), 32'(h == OWN_INST));
            chk({tag, "_ddok"}, 32'(data_data_ok), 32'(h == OWN_DATA));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        owner_t      w, w2, r;
        logic [31:0] exp_req;

        rst = 1'b1;
        model_last = OWN_INST;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = SZ_WORD;
        inst_addr = '0; inst_wdata = 32'h1111_1111;
        data_req = 1'b0; data_wr = 1'b0; data_size = SZ_WORD;
        data_addr = '0; data_wdata = '0;
        mem_rdata = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        idle_check("rst");

        // Single inst read, response three cycles after the grant.
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
        #1;
        chk_grant("t1", OWN_INST, 32'hBFC0_0000);
        chk("t1_size", 32'(mem_size), 32'(SZ_WORD));
        chk("t1_wr",   32'(mem_wr),   32'd0);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk("t1_early_idok", 32'(inst_data_ok), 32'd0);
        tick();
        tick();
        resp_drive("t1", 32'h1234_5678);
        tick();
        mem_data_ok = 1'b0;

        // Two simultaneous pairs fill the queue; the leftover request is masked until a pop.
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SZ_WORD; inst_addr = 32'h1000_0000;
        data_req = 1'b1; data_wr = 1'b1; data_size = SZ_HALF; data_addr = 32'h2000_0004;
        data_wdata = 32'hCAFE_BABE; mem_addr_ok = 1'b1;
        #1;
        w = both_winner();
        chk_grant("t2a", w, (w == OWN_DATA) ? data_addr : inst_addr);
        chk("t2a_wr",    32'(mem_wr), 32'(w == OWN_DATA));
        chk("t2a_size",  32'(mem_size), (w == OWN_DATA) ? 32'(SZ_HALF) : 32'(SZ_WORD));
        chk("t2a_wdata", mem_wdata, (w == OWN_DATA) ? 32'hCAFE_BABE : 32'h1111_1111);
        tick();
        if (w == OWN_DATA) data_addr = 32'h2000_0008;
        else               inst_addr = 32'h1000_0004;
        #1;
        w2 = both_winner();
        chk_grant("t2b", w2, (w2 == OWN_DATA) ? data_addr : inst_addr);
        tick();
        if (w2 == OWN_DATA) begin data_req = 1'b0; r = OWN_INST; end
        else                begin inst_req = 1'b0; r = OWN_DATA; end
        exp_req = 32'(exp_q.size() < DEPTH);
        resp_drive("t2c", 32'hA5A5_0001);
        chk("t2c_mreq", 32'(mem_req),      exp_req);
        chk("t2c_iaok", 32'(inst_addr_ok), 32'd0);
        chk("t2c_daok", 32'(data_addr_ok), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        #1;
        chk_grant("t2d", r, (r == OWN_DATA) ? data_addr : inst_addr);
        tick();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        resp_drive("t2e", 32'h0000_00E1);
        tick();
        mem_data_ok = 1'b0;
        resp_drive("t2f", 32'h0000_00F2);
        tick();
        mem_data_ok = 1'b0;

        // Inst holds the port while addr_ok is low even after data starts requesting.
        inst_req = 1'b1; inst_addr = 32'h3000_0000;
        data_wr = 1'b0; data_addr = 32'h4000_0000;
        #1;
        chk("t3_mreq",  32'(mem_req), 32'd1);
        chk("t3_maddr", mem_addr, 32'h3000_0000);
        chk("t3_iaok",  32'(inst_addr_ok), 32'd0);
        tick();
        data_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_lock_maddr", mem_addr, 32'h3000_0000);
            chk("t3_lock_daok",  32'(data_addr_ok), 32'd0);
            chk("t3_lock_iaok",  32'(inst_addr_ok), 32'd0);
            tick();
        end
        mem_addr_ok = 1'b1;
        #1;
        chk_grant("t3g", OWN_INST, 32'h3000_0000);
        tick();
        inst_req = 1'b0;
        #1;
        chk_grant("t3d", OWN_DATA, 32'h4000_0000);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        resp_drive("t3r1", 32'h3333_0001);
        tick();
        mem_data_ok = 1'b0;
        resp_drive("t3r2", 32'h4444_0002);
        tick();
        mem_data_ok = 1'b0;

        // Stray response with nothing outstanding.
        resp_drive("t4", 32'hDEAD_0000);
        tick();
        mem_data_ok = 1'b0;

        // Reset with one outstanding transaction and the port locked to inst.
        inst_req = 1'b1; inst_addr = 32'h5000_0000; mem_addr_ok = 1'b1;
        #1;
        chk_grant("t5a", OWN_INST, 32'h5000_0000);
        tick();
        inst_addr = 32'h5000_0004; mem_addr_ok = 1'b0;
        #1;
        chk("t5_lock_mreq", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1; inst_req = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_last = OWN_INST;
        #1;
        idle_check("t5_post");
        resp_drive("t5_stray", 32'hBAD0_0001);
        tick();
        mem_data_ok = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h6000_0000;
        data_req = 1'b1; data_addr = 32'h7000_0000; mem_addr_ok = 1'b1;
        #1;
        w = both_winner();
        chk_grant("t5b", w, (w == OWN_DATA) ? 32'h7000_0000 : 32'h6000_0000);
        tick();
        if (w == OWN_DATA) begin data_req = 1'b0; r = OWN_INST; end
        else               begin inst_req = 1'b0; r = OWN_DATA; end
        #1;
        chk_grant("t5c", r, (r == OWN_DATA) ? 32'h7000_0000 : 32'h6000_0000);
        tick();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        resp_drive("t5r1", 32'h5555_0001);
        tick();
        mem_data_ok = 1'b0;
        resp_drive("t5r2", 32'h5555_0002);
        tick();
        mem_data_ok = 1'b0;
        #1;
        idle_check("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
